// File: rtl/bus_arbiter2_if.sv
// Bundle of the two upstream master ports and the single downstream port
// seen by bus_arbiter2. The slave modport is the arbiter's view; the master
// modport is the view of whatever drives the masters and the downstream slave.
interface bus_arbiter2_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_a_rw;
  logic                  i_a_request;
  logic                  o_a_ready;
  logic [ADDR_WIDTH-1:0] i_a_address;
  logic [DATA_WIDTH-1:0] o_a_rdata;
  logic [DATA_WIDTH-1:0] i_a_wdata;

  logic                  i_b_rw;
  logic                  i_b_request;
  logic                  o_b_ready;
  logic [ADDR_WIDTH-1:0] i_b_address;
  logic [DATA_WIDTH-1:0] o_b_rdata;
  logic [DATA_WIDTH-1:0] i_b_wdata;

  logic                  o_bus_rw;
  logic                  o_bus_request;
  logic                  i_bus_ready;
  logic [ADDR_WIDTH-1:0] o_bus_address;
  logic [DATA_WIDTH-1:0] i_bus_rdata;
  logic [DATA_WIDTH-1:0] o_bus_wdata;

  modport slave (
    input  i_a_rw, i_a_request, i_a_address, i_a_wdata,
    input  i_b_rw, i_b_request, i_b_address, i_b_wdata,
    input  i_bus_ready, i_bus_rdata,
    output o_a_ready, o_a_rdata, o_b_ready, o_b_rdata,
    output o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata
  );

  modport master (
    output i_a_rw, i_a_request, i_a_address, i_a_wdata,
    output i_b_rw, i_b_request, i_b_address, i_b_wdata,
    output i_bus_ready, i_bus_rdata,
    input  o_a_ready, o_a_rdata, o_b_ready, o_b_rdata,
    input  o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata
  );
endinterface

// File: rtl/bus_arbiter2.sv
// Two-master arbiter in front of the CPU-side port of the bus timing
// controller. Master A = load/store data port, master B = instruction fetch.
// A grant is held until the owning master drops its request, followed by one
// forced-idle TURNAROUND cycle before the next arbitration.
// Optional feature: define BUS_ARBITER2_ROUND_ROBIN_EN to alternate the winner
// of simultaneous requests; otherwise master A always wins a tie.
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE        | no owner; arbitrate pending requests, bus request low
// GRANT_A     | master A owns the downstream port
// GRANT_B     | master B owns the downstream port
// TURNAROUND  | one cycle of request low after a release
module bus_arbiter2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic          i_clock,
  input logic          i_reset,
  bus_arbiter2_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANT_A    = 2'd1,
    ST_GRANT_B    = 2'd2,
    ST_TURNAROUND = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;   // 0 = A, 1 = B
  logic   tie_pick_b;

  logic                  bus_rw;
  logic                  bus_request;
  logic [ADDR_WIDTH-1:0] bus_address;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  a_ready;
  logic                  b_ready;

  // State and last-grant registers; last_grant resets to B so A wins the first tie.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Tie-break choice when both masters request in IDLE.
  always_comb begin
    tie_pick_b = 1'b0;
`ifdef BUS_ARBITER2_ROUND_ROBIN_EN
    tie_pick_b = ~last_grant_q;
`endif
  end

  // Next-state: arbitrate in IDLE, hold grant until the owner releases.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_a_request && !(bus.i_b_request && tie_pick_b)) begin
          state_d      = ST_GRANT_A;
          last_grant_d = 1'b0;
        end else if (bus.i_b_request) begin
          state_d      = ST_GRANT_B;
          last_grant_d = 1'b1;
        end
      end
      ST_GRANT_A: begin
        if (!bus.i_a_request) state_d = ST_TURNAROUND;
      end
      ST_GRANT_B: begin
        if (!bus.i_b_request) state_d = ST_TURNAROUND;
      end
      ST_TURNAROUND: state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Downstream mux and ready return, selected only by registered state.
  always_comb begin
    bus_rw      = bus.i_a_rw;
    bus_address = bus.i_a_address;
    bus_wdata   = bus.i_a_wdata;
    bus_request = 1'b0;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    case (state_q)
      ST_GRANT_A: begin
        bus_request = bus.i_a_request;
        a_ready     = bus.i_bus_ready && bus.i_a_request;
      end
      ST_GRANT_B: begin
        bus_rw      = bus.i_b_rw;
        bus_address = bus.i_b_address;
        bus_wdata   = bus.i_b_wdata;
        bus_request = bus.i_b_request;
        b_ready     = bus.i_bus_ready && bus.i_b_request;
      end
      default: ;
    endcase
  end

  assign bus.o_bus_rw      = bus_rw;
  assign bus.o_bus_request = bus_request;
  assign bus.o_bus_address = bus_address;
  assign bus.o_bus_wdata   = bus_wdata;
  assign bus.o_a_ready     = a_ready;
  assign bus.o_b_ready     = b_ready;
  // Read data is broadcast; ready alone qualifies it for each master.
  assign bus.o_a_rdata     = bus.i_bus_rdata;
  assign bus.o_b_rdata     = bus.i_bus_rdata;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Bench for bus_arbiter2: directed scenarios followed by random traffic, with
// a transaction-level ownership model checked every cycle.
module tb_bus_arbiter2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  bus_arbiter2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bif)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

`ifdef BUS_ARBITER2_ROUND_ROBIN_EN
  bit rr_mode = 1'b1;
`else
  bit rr_mode = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, whether the post-release quiet cycle
  // is pending, and who won last (0=A, 1=B).
  int m_owner = -1;
  bit m_quiet = 0;
  int m_last  = 1;

  always @(posedge clk) begin
    bit ra, rb;
    ra = bif.i_a_request;
    rb = bif.i_b_request;
    if (rst) begin
      m_owner = -1; m_quiet = 0; m_last = 1;
    end else if (m_owner == 0 && !ra || m_owner == 1 && !rb) begin
      m_owner = -1; m_quiet = 1;
    end else if (m_owner >= 0) begin
      // owner keeps the bus regardless of the other master
    end else if (m_quiet) begin
      m_quiet = 0;
    end else if (ra || rb) begin
      if (ra && rb) m_owner = rr_mode ? 1 - m_last : 0;
      else          m_owner = rb ? 1 : 0;
      m_last = m_owner;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit sel_b, e_req;
      sel_b = (m_owner == 1);
      e_req = (m_owner == 0) ? bif.i_a_request : (m_owner == 1) ? bif.i_b_request : 1'b0;
      chk("m_bus_req",  bif.o_bus_request, e_req);
      chk("m_bus_rw",   bif.o_bus_rw,      sel_b ? bif.i_b_rw : bif.i_a_rw);
      chk("m_bus_addr", bif.o_bus_address, sel_b ? bif.i_b_address : bif.i_a_address);
      chk("m_bus_wd",   bif.o_bus_wdata,   sel_b ? bif.i_b_wdata : bif.i_a_wdata);
      chk("m_a_ready",  bif.o_a_ready, (m_owner == 0) && bif.i_bus_ready && bif.i_a_request);
      chk("m_b_ready",  bif.o_b_ready, (m_owner == 1) && bif.i_bus_ready && bif.i_b_request);
      chk("m_a_rdata",  bif.o_a_rdata, bif.i_bus_rdata);
      chk("m_b_rdata",  bif.o_b_rdata, bif.i_bus_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.i_a_request = 0; bif.i_b_request = 0; bif.i_bus_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int exp_order[5];
    bit a_rdy, b_rdy, a_hold, prev_req, started, got;
    int gap;

    bif.i_a_rw = 0; bif.i_a_request = 0; bif.i_a_address = '0; bif.i_a_wdata = '0;
    bif.i_b_rw = 0; bif.i_b_request = 0; bif.i_b_address = '0; bif.i_b_wdata = '0;
    bif.i_bus_ready = 0; bif.i_bus_rdata = '0;
    do_reset();
    chk_en = 1;
    #3;
    chk("rst_req", bif.o_bus_request, 0);
    chk("rst_a_ready", bif.o_a_ready, 0);
    chk("rst_b_ready", bif.o_b_ready, 0);

    // Single master A read with slave ready two cycles after the request.
    step(); bif.i_a_rw = 0; bif.i_a_address = 32'h0000_1000; bif.i_a_request = 1;
    #3 chk("t1_req_lo", bif.o_bus_request, 0);
    step(); #3 chk("t1_req_hi", bif.o_bus_request, 1);
    chk("t1_addr", bif.o_bus_address, 32'h0000_1000);
    step(); #3 chk("t1_wait_rdy", bif.o_a_ready, 0);
    step(); bif.i_bus_ready = 1; bif.i_bus_rdata = 32'hDEAD_BEEF;
    #3 chk("t1_a_ready", bif.o_a_ready, 1);
    chk("t1_rdata", bif.o_a_rdata, 32'hDEAD_BEEF);
    chk("t1_b_ready", bif.o_b_ready, 0);
    step(); bif.i_a_request = 0; bif.i_bus_ready = 0;
    #3 chk("t1_release", bif.o_bus_request, 0);
    step(); bif.i_a_request = 1;
    #3 chk("t1_turn", bif.o_bus_request, 0);
    step(); #3 chk("t1_idle", bif.o_bus_request, 0);
    step(); #3 chk("t1_regrant", bif.o_bus_request, 1);
    step(); idle_inputs();

    // Contention: both masters re-request right after each completion.
    exp_order = rr_mode ? '{0, 1, 0, 1, 1} : '{0, 0, 0, 0, 1};
    do_reset();
    a_rdy = 0; b_rdy = 0; a_hold = 0; prev_req = 0; started = 0; gap = 0;
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      step();
      bif.i_bus_ready = 1;
      bif.i_a_request = !a_hold && !a_rdy;
      bif.i_b_request = !b_rdy;
      #3;
      a_rdy = bif.o_a_ready;
      b_rdy = bif.o_b_ready;
      if (a_rdy) order.push_back(0);
      if (b_rdy) order.push_back(1);
      if (order.size() == 4) a_hold = 1;
      if (bif.o_bus_request) begin
        if (!prev_req && started) chk("ct_gap", gap >= 2, 1);
        started = 1; gap = 0;
      end else gap++;
      prev_req = bif.o_bus_request;
    end
    chk("ct_count", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("ct_order", order[i], exp_order[i]);
    step(); idle_inputs();

    // Non-preemption: B write in flight, A requests mid-transfer.
    do_reset();
    step(); bif.i_b_rw = 1; bif.i_b_address = 32'h8000_0000; bif.i_b_wdata = 32'h1234_5678;
    bif.i_b_request = 1;
    step(); #3 chk("np_b_addr", bif.o_bus_address, 32'h8000_0000);
    step(); bif.i_a_rw = 0; bif.i_a_address = 32'h0000_2000; bif.i_a_wdata = 32'hAAAA_5555;
    bif.i_a_request = 1;
    for (int c = 0; c < 3; c++) begin
      step(); #3;
      chk("np_hold_addr", bif.o_bus_address, 32'h8000_0000);
      chk("np_hold_wd", bif.o_bus_wdata, 32'h1234_5678);
      chk("np_hold_rw", bif.o_bus_rw, 1);
      chk("np_no_a_rdy", bif.o_a_ready, 0);
    end
    step(); bif.i_bus_ready = 1;
    #3 chk("np_b_ready", bif.o_b_ready, 1);
    step(); bif.i_b_request = 0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      step(); #3;
      if (bif.o_a_ready) begin
        got = 1;
        chk("np_a_addr", bif.o_bus_address, 32'h0000_2000);
      end
    end
    chk("np_a_granted", got, 1);
    step(); idle_inputs();

    // Reset while A is mid-transfer with no ready yet.
    do_reset();
    step(); bif.i_a_address = 32'h0000_3000; bif.i_a_request = 1;
    step(); #3 chk("rm_granted", bif.o_bus_request, 1);
    step(); rst = 1;
    step(); rst = 0;
    #3 chk("rm_req_drop", bif.o_bus_request, 0);
    chk("rm_no_ready", bif.o_a_ready, 0);
    bif.i_a_request = 0;
    step(); step();

    // Ready from the slave with nobody requesting is ignored.
    do_reset();
    bif.i_bus_ready = 1;
    for (int c = 0; c < 5; c++) begin
      step(); #3;
      chk("sp_a_ready", bif.o_a_ready, 0);
      chk("sp_b_ready", bif.o_b_ready, 0);
    end
    idle_inputs();

    // Random traffic: masters hold until ready, occasionally abandon early.
    do_reset();
    a_rdy = 0; b_rdy = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      rst = ($urandom_range(0, 149) == 0);
      bif.i_bus_ready = ($urandom_range(0, 2) == 0);
      bif.i_bus_rdata = $urandom;
      if (bif.i_a_request) begin
        if (a_rdy || $urandom_range(0, 15) == 0) bif.i_a_request = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        bif.i_a_request = 1; bif.i_a_rw = $urandom_range(0, 1);
        bif.i_a_address = $urandom; bif.i_a_wdata = $urandom;
      end
      if (bif.i_b_request) begin
        if (b_rdy || $urandom_range(0, 15) == 0) bif.i_b_request = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        bif.i_b_request = 1; bif.i_b_rw = $urandom_range(0, 1);
        bif.i_b_address = $urandom; bif.i_b_wdata = $urandom;
      end
      #3;
      a_rdy = bif.o_a_ready;
      b_rdy = bif.o_b_ready;
    end
    rst = 0;
    step(); idle_inputs();
    step(); step();
    chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
